morse_msg_sequencer: RTL and testbench

- Message-level controller that buffers a queue of letter codes and word-space markers, and hands them one at a time to the single-letter Morse emitter.
- For each letter it drives the 3-bit letter select and a one-cycle start pulse, then waits for the emitter to finish, then times the inter-letter or inter-word gap before moving to the next entry.
- Sits between the switch/keypad front end and the Morse letter emitter (symbol/mask select, shift registers and LED FSM).

---
 rtl/morse_msg_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_morse_msg_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_msg_sequencer.sv
// Message-level Morse sequencer: queues letter codes and word-space markers and
// hands letters one at a time to the single-letter emitter, timing the gaps between them.
module morse_msg_sequencer #(
  parameter int unsigned DEPTH            = 8,
  parameter int unsigned UNIT_CYCLES      = 25000000,
  parameter int unsigned LETTER_GAP_UNITS = 3,
  parameter int unsigned WORD_GAP_UNITS   = 7,
  parameter int unsigned ACK_TIMEOUT      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  input  logic [2:0]             wr_letter,
  input  logic                   wr_space,
  output logic                   wr_ready,
  input  logic                   abort,
  output logic [2:0]             letter_sel,
  output logic                   letter_start,
  input  logic                   letter_busy,
  output logic                   seq_busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   ack_err
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned UNIT_W  = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int unsigned GAP_MAX = (LETTER_GAP_UNITS > WORD_GAP_UNITS) ? LETTER_GAP_UNITS
                                                                        : WORD_GAP_UNITS;
  localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);
  localparam int unsigned ACK_W   = $clog2(ACK_TIMEOUT + 1);

  localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_CYCLES - 1);
  localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPATCH,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [2:0]        sel_q, sel_d;
  logic              space_q, space_d;
  logic [UNIT_W-1:0] unit_q, unit_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [ACK_W-1:0]  ack_q, ack_d;
  logic              overflow_q, overflow_d;
  logic              ack_err_q, ack_err_d;

  logic              full;
  logic              push;
  logic              pop;
  logic [3:0]        head;

  always_comb begin
    full         = (count_q == CNT_W'(DEPTH));
    // wr_ready is held low while reset is asserted so every output reads 0 in reset.
    wr_ready     = reset & ~full;
    push         = wr_valid & ~full & ~abort;
    pop          = (state_q == S_IDLE) & (count_q != '0) & ~abort;
    head         = mem_q[rd_ptr_q];
    letter_start = (state_q == S_DISPATCH) & ~space_q & ~abort;
    seq_busy     = (state_q != S_IDLE) | (count_q != '0);
    fifo_count   = count_q;
    letter_sel   = sel_q;
    overflow     = overflow_q;
    ack_err      = ack_err_q;
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    sel_d      = sel_q;
    space_d    = space_q;
    unit_d     = unit_q;
    gap_d      = gap_q;
    ack_d      = ack_q;
    overflow_d = overflow_q | (wr_valid & full);
    ack_err_d  = ack_err_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      sel_d    = head[2:0];
      space_d  = head[3];
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: ;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (pop) state_d = S_DISPATCH;
      end
      S_DISPATCH: begin
        if (space_q) begin
          gap_d   = GAP_W'(WORD_GAP_UNITS);
          unit_d  = '0;
          state_d = S_GAP;
        end else begin
          // Count from the start pulse itself so the timeout is measured from letter_start.
          ack_d   = ACK_W'(1);
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (letter_busy) begin
          state_d = S_WAIT_DONE;
        end else if (ack_q >= ACK_LAST) begin
          ack_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          ack_d = ack_q + ACK_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!letter_busy) begin
          gap_d   = GAP_W'(LETTER_GAP_UNITS);
          unit_d  = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (unit_q == UNIT_LAST) begin
          unit_d = '0;
          if (gap_q <= GAP_W'(1)) begin
            gap_d   = '0;
            state_d = S_IDLE;
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end else begin
          unit_d = unit_q + UNIT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d  = S_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      unit_d   = '0;
      gap_d    = '0;
      ack_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {wr_space, wr_letter};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sel_q      <= '0;
      space_q    <= 1'b0;
      unit_q     <= '0;
      gap_q      <= '0;
      ack_q      <= '0;
      overflow_q <= 1'b0;
      ack_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sel_q      <= sel_d;
      space_q    <= space_d;
      unit_q     <= unit_d;
      gap_q      <= gap_d;
      ack_q      <= ack_d;
      overflow_q <= overflow_d;
      ack_err_q  <= ack_err_d;
    end
  end

endmodule

// File: tb/tb_morse_msg_sequencer.sv
// Directed bench for morse_msg_sequencer with a behavioural letter emitter and a
// scoreboard of expected start codes.
module tb_morse_msg_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_valid = 1'b0;
  logic [2:0] wr_letter = '0;
  logic       wr_space = 1'b0;
  logic       wr_ready;
  logic       abort = 1'b0;
  logic [2:0] letter_sel;
  logic       letter_start;
  logic       letter_busy;
  logic       seq_busy;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       ack_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_q[$];
  int start_at[$];
  bit em_on = 1'b1;
  int em_cnt = 0;

  morse_msg_sequencer #(
    .DEPTH(4),
    .UNIT_CYCLES(4),
    .LETTER_GAP_UNITS(3),
    .WORD_GAP_UNITS(7),
    .ACK_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_valid(wr_valid),
    .wr_letter(wr_letter),
    .wr_space(wr_space),
    .wr_ready(wr_ready),
    .abort(abort),
    .letter_sel(letter_sel),
    .letter_start(letter_start),
    .letter_busy(letter_busy),
    .seq_busy(seq_busy),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .ack_err(ack_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Emitter: busy rises one clock after the start pulse and stays up for 10 clocks.
  always @(posedge clk or negedge reset) begin
    if (!reset) em_cnt <= 0;
    else if (em_on && letter_start) em_cnt <= 10;
    else if (em_cnt != 0) em_cnt <= em_cnt - 1;
  end
  assign letter_busy = (em_cnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && letter_start) begin
      int e;
      start_at.push_back(cyc);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8;
      check("start_sel", {29'b0, letter_sel}, e);
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic push_entry(input int code, input bit sp, input bit expect_start);
    wr_valid  = 1'b1;
    wr_letter = 3'(code);
    wr_space  = sp;
    if (expect_start) exp_q.push_back(code);
    align();
    wr_valid  = 1'b0;
    wr_space  = 1'b0;
  endtask

  task automatic wait_nstarts(input int n, input int budget);
    for (int i = 0; i < budget && start_at.size() < n; i++) align();
    check("start_seen", start_at.size() >= n, 1);
  endtask

  task automatic wait_idle(input int budget, output int c);
    c = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!seq_busy) begin
        c = cyc;
        break;
      end
    end
  endtask

  task automatic at_cycle(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, d, d2, c, n0;
    int codes[6] = '{2, 4, 6, 7, 0, 1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_start", letter_start, 0);
    check("rst_sel", letter_sel, 0);
    check("rst_seq_busy", seq_busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_ack_err", ack_err, 0);
    align();
    reset = 1'b1;
    @(negedge clk);
    check("rel_wr_ready", wr_ready, 1);

    // Single letter: latency, busy, letter gap
    align();
    n0 = start_at.size();
    p = cyc;
    push_entry(3, 1'b0, 1'b1);
    wait_nstarts(n0 + 1, 20);
    d = start_at[n0];
    check("t1_latency", d - p, 2);
    wait_idle(60, c);
    check("t1_idle_at", c - d, 24);

    // Letter, space, letter
    align();
    n0 = start_at.size();
    p = cyc;
    push_entry(1, 1'b0, 1'b1);
    push_entry(0, 1'b1, 1'b0);
    push_entry(5, 1'b0, 1'b1);
    wait_nstarts(n0 + 2, 120);
    d = start_at[n0];
    d2 = start_at[n0 + 1];
    check("t2_latency", d - p, 2);
    check("t2_start_spacing", d2 - d, 55);
    wait_idle(60, c);
    check("t2_idle", c >= 0, 1);

    // Overflow
    align();
    n0 = start_at.size();
    p = cyc;
    check("t3_no_ovf_yet", overflow, 0);
    for (int i = 0; i < 6; i++) begin
      wr_valid  = 1'b1;
      wr_letter = 3'(codes[i]);
      if (i < 5) exp_q.push_back(codes[i]);
      if (i == 4) begin
        @(negedge clk);
        check("t3_count3", fifo_count, 3);
      end
      if (i == 5) begin
        @(negedge clk);
        check("t3_full_ready", wr_ready, 0);
        check("t3_full_count", fifo_count, 4);
      end
      align();
    end
    wr_valid = 1'b0;
    @(negedge clk);
    check("t3_overflow", overflow, 1);
    wait_nstarts(n0 + 5, 200);
    check("t3_latency", start_at[n0] - p, 2);
    for (int k = 1; k < 5; k++) check("t3_spacing", start_at[n0 + k] - start_at[n0 + k - 1], 25);
    wait_idle(60, c);
    check("t3_idle", c >= 0, 1);

    // Emitter never acknowledges
    em_on = 1'b0;
    check("t4_ack_err_clear", ack_err, 0);
    align();
    n0 = start_at.size();
    push_entry(3, 1'b0, 1'b1);
    push_entry(6, 1'b0, 1'b1);
    wait_nstarts(n0 + 1, 20);
    d = start_at[n0];
    at_cycle(d + 3);
    check("t4_ack_err_early", ack_err, 0);
    at_cycle(d + 4);
    check("t4_ack_err_set", ack_err, 1);
    wait_nstarts(n0 + 2, 20);
    check("t4_next_no_gap", start_at[n0 + 1] - d, 5);
    wait_idle(30, c);
    check("t4_idle_at", c - d, 9);
    em_on = 1'b1;

    // Abort during WAIT_DONE with 3 entries queued
    align();
    n0 = start_at.size();
    push_entry(1, 1'b0, 1'b1);
    push_entry(2, 1'b0, 1'b0);
    push_entry(3, 1'b0, 1'b0);
    push_entry(4, 1'b0, 1'b0);
    wait_nstarts(n0 + 1, 20);
    d = start_at[n0];
    at_cycle(d + 3);
    check("t5_pre_abort_count", fifo_count, 3);
    align();
    abort     = 1'b1;
    wr_valid  = 1'b1;
    wr_letter = 3'd7;
    align();
    abort    = 1'b0;
    wr_valid = 1'b0;
    @(negedge clk);
    check("t5_abort_count", fifo_count, 0);
    check("t5_abort_idle", seq_busy, 0);
    check("t5_abort_ovf_held", overflow, 1);
    at_cycle(d + 45);
    check("t5_no_more_starts", start_at.size(), n0 + 1);
    align();
    p = cyc;
    push_entry(5, 1'b0, 1'b1);
    wait_nstarts(n0 + 2, 20);
    check("t5_after_abort_latency", start_at[n0 + 1] - p, 2);
    wait_idle(60, c);
    check("t5_idle", c >= 0, 1);

    // Reset mid-GAP
    align();
    n0 = start_at.size();
    push_entry(6, 1'b0, 1'b1);
    wait_nstarts(n0 + 1, 20);
    d = start_at[n0];
    at_cycle(d + 15);
    check("t6_busy_in_gap", seq_busy, 1);
    check("t6_ack_err_held", ack_err, 1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_seq_busy", seq_busy, 0);
    check("t6_async_sel", letter_sel, 0);
    check("t6_async_overflow", overflow, 0);
    check("t6_async_ack_err", ack_err, 0);
    check("t6_async_wr_ready", wr_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("t6_rel_count", fifo_count, 0);
    check("t6_rel_ready", wr_ready, 1);
    check("t6_rel_seq_busy", seq_busy, 0);
    align();
    n0 = start_at.size();
    p = cyc;
    push_entry(2, 1'b0, 1'b1);
    wait_nstarts(n0 + 1, 20);
    check("t6_post_latency", start_at[n0] - p, 2);
    wait_idle(60, c);
    check("t6_idle_at", c - start_at[n0], 24);

    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
